// File: rtl/mac_share_arbiter.sv
// mac_share_arbiter
// Round-robin front end for one shared pipelined multiply-add unit.
// Requesters hold REQ with their operands until granted. The winner's operands
// pass through two input stages, and then RES = A*B + C is registered together
// with the winner's ID. STALL freezes the arbiter and every pipeline stage.

module mac_share_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2,
  parameter int DW    = 8
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [N_REQ-1:0]    REQ,
  input  logic [N_REQ*DW-1:0] A_IN,
  input  logic [N_REQ*DW-1:0] B_IN,
  input  logic [N_REQ*DW-1:0] C_IN,
  input  logic                STALL,
  output logic [N_REQ-1:0]    GNT,
  output logic                RES_VALID,
  output logic [2*DW-1:0]     RES,
  output logic [ID_W-1:0]     RES_ID,
  output logic                BUSY
);

  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] ptr_next;
  logic            accept;
  logic [ID_W-1:0] win_id;
  logic [DW-1:0]   win_a;
  logic [DW-1:0]   win_b;
  logic [DW-1:0]   win_c;

  logic            s1_valid;
  logic [DW-1:0]   s1_a;
  logic [DW-1:0]   s1_b;
  logic [DW-1:0]   s1_c;
  logic [ID_W-1:0] s1_id;

  logic            s2_valid;
  logic [DW-1:0]   s2_a;
  logic [DW-1:0]   s2_b;
  logic [DW-1:0]   s2_c;
  logic [ID_W-1:0] s2_id;

  logic [2*DW-1:0] mac_sum;

  // Round-robin search from the pointer with wrap-around. Reset and stall suppress the grant.
  always_comb begin
    int idx;
    idx    = 0;
    GNT    = '0;
    accept = 1'b0;
    win_id = '0;
    if (!RST && !STALL) begin
      for (int i = 0; i < N_REQ; i++) begin
        idx = (int'(ptr) + i) % N_REQ;
        if (!accept && REQ[idx]) begin
          accept = 1'b1;
          win_id = ID_W'(idx);
        end
      end
    end
    if (accept) begin
      GNT[win_id] = 1'b1;
    end
  end

  assign ptr_next = ID_W'((int'(win_id) + 1) % N_REQ);
  assign win_a    = A_IN[int'(win_id)*DW +: DW];
  assign win_b    = B_IN[int'(win_id)*DW +: DW];
  assign win_c    = C_IN[int'(win_id)*DW +: DW];

  // Operands are zero-extended before the multiply. The worst case, 255*255+255, still fits in 2*DW bits.
  assign mac_sum = {{DW{1'b0}}, s2_a} * {{DW{1'b0}}, s2_b} + {{DW{1'b0}}, s2_c};

  assign BUSY = s1_valid | s2_valid | RES_VALID;

  // Priority pointer: after an accept, the pointer moves to one past the winner.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ptr <= '0;
    end else if (accept) begin
      ptr <= ptr_next;
    end
  end

  // Two operand stages and the result register. All of them advance together unless STALL is high.
  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      RES_VALID <= 1'b0;
      RES       <= '0;
      RES_ID    <= '0;
    end else if (!STALL) begin
      s1_valid <= accept;
      if (accept) begin
        s1_a  <= win_a;
        s1_b  <= win_b;
        s1_c  <= win_c;
        s1_id <= win_id;
      end
      s2_valid <= s1_valid;
      s2_a     <= s1_a;
      s2_b     <= s1_b;
      s2_c     <= s1_c;
      s2_id    <= s1_id;
      RES_VALID <= s2_valid;
      if (s2_valid) begin
        RES    <= mac_sum;
        RES_ID <= s2_id;
      end
    end
  end

endmodule

// File: tb/tb_mac_share_arbiter.sv
// tb_mac_share_arbiter
// Random and directed traffic against a request/queue reference model.
// Expected results are queued at each accept. A negedge monitor pops one
// entry for each new result and checks grant, valid, busy and the held output values.

module tb_mac_share_arbiter;

  localparam int N  = 4;
  localparam int IW = 2;
  localparam int DW = 8;

  logic            CLK = 1'b0;
  logic            RST;
  logic [N-1:0]    REQ;
  logic [N*DW-1:0] A_IN;
  logic [N*DW-1:0] B_IN;
  logic [N*DW-1:0] C_IN;
  logic            STALL;
  logic [N-1:0]    GNT;
  logic            RES_VALID;
  logic [2*DW-1:0] RES;
  logic [IW-1:0]   RES_ID;
  logic            BUSY;

  mac_share_arbiter #(.N_REQ(N), .ID_W(IW), .DW(DW)) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .A_IN(A_IN), .B_IN(B_IN), .C_IN(C_IN),
    .STALL(STALL), .GNT(GNT), .RES_VALID(RES_VALID), .RES(RES),
    .RES_ID(RES_ID), .BUSY(BUSY)
  );

  // Free-running clock, posedge at 5, 15, ...
  always #5 CLK = ~CLK;

  typedef struct {
    int id;
    int res;
    int label;
  } exp_t;

  exp_t        sb[$];
  bit          accepted[int];
  int          adv = 0;
  int          ptr_m = 0;
  int          total = 0;
  int          bad = 0;
  int          last_res = 0;
  int          last_id = 0;
  bit          started = 0;
  bit          last_adv = 0;
  bit          done = 0;
  bit          reported = 0;
  logic [N-1:0] exp_gnt = '0;
  bit          pend[N];
  logic [DW-1:0] opa[N];
  logic [DW-1:0] opb[N];
  logic [DW-1:0] opc[N];

  bit   mon_ev;
  bit   mon_eb;
  exp_t mon_e;

  // One comparison. A mismatch prints a single FAIL line.
  task automatic checkOutput(input string name, input int act, input int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  // A requester raises REQ with new operands.
  task automatic setOp(input int i, input int a, input int b, input int c);
    pend[i] = 1'b1;
    opa[i]  = DW'(a);
    opb[i]  = DW'(b);
    opc[i]  = DW'(c);
  endtask

  // Drive one cycle of inputs, predict the grant, then update the model at the clock edge.
  task automatic applyStimulus(input bit rst, input bit stall);
    int win;
    RST   = rst;
    STALL = stall;
    for (int i = 0; i < N; i++) begin
      REQ[i]            = pend[i];
      A_IN[i*DW +: DW]  = opa[i];
      B_IN[i*DW +: DW]  = opb[i];
      C_IN[i*DW +: DW]  = opc[i];
    end
    win = -1;
    if (!rst && !stall) begin
      for (int j = 0; j < N; j++) begin
        if (win < 0 && pend[(ptr_m + j) % N]) win = (ptr_m + j) % N;
      end
    end
    exp_gnt = '0;
    if (win >= 0) exp_gnt[win] = 1'b1;
    @(posedge CLK);
    last_adv = 1'b0;
    if (rst) begin
      sb.delete();
      accepted.delete();
      ptr_m    = 0;
      last_res = 0;
      last_id  = 0;
    end else if (!stall) begin
      adv++;
      last_adv = 1'b1;
      if (win >= 0) begin
        sb.push_back('{win, int'(opa[win]) * int'(opb[win]) + int'(opc[win]), adv});
        accepted[adv] = 1'b1;
        ptr_m     = (win + 1) % N;
        pend[win] = 1'b0;
      end
    end
    #1;
  endtask

  // Monitor: an op accepted at label L is in S1 while adv==L, in S2 at L+1, and at the output at L+2.
  always @(negedge CLK) begin
    if (started && !reported) begin
      mon_ev = accepted.exists(adv - 2);
      mon_eb = accepted.exists(adv) || accepted.exists(adv - 1) || mon_ev;
      checkOutput("gnt", int'(GNT), int'(exp_gnt));
      checkOutput("res_valid", int'(RES_VALID), int'(mon_ev));
      checkOutput("busy", int'(BUSY), int'(mon_eb));
      if (RES_VALID && last_adv) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_result", 1, 0);
        end else begin
          mon_e = sb.pop_front();
          checkOutput("res_id", int'(RES_ID), mon_e.id);
          checkOutput("res", int'(RES), mon_e.res);
          checkOutput("latency", adv - 2, mon_e.label);
          last_res = mon_e.res;
          last_id  = mon_e.id;
        end
      end else begin
        checkOutput("res_hold", int'(RES), last_res);
        checkOutput("res_id_hold", int'(RES_ID), last_id);
      end
      if (done) begin
        checkOutput("drain_empty", sb.size(), 0);
        reported = 1'b1;
      end
    end
  end

  // Directed scenarios first, then random traffic, then a bounded drain.
  initial begin
    RST = 1'b1; STALL = 1'b0; REQ = '0; A_IN = '0; B_IN = '0; C_IN = '0;
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b0; opa[i] = '0; opb[i] = '0; opc[i] = '0;
    end
    applyStimulus(1, 0);
    started = 1'b1;

    // Single op on requester 0
    setOp(0, 12, 10, 5);
    repeat (6) applyStimulus(0, 0);

    // All four requesters held high; refill with fresh operands as each is served
    for (int c = 0; c < 8; c++) begin
      for (int i = 0; i < N; i++) if (!pend[i]) setOp(i, 20 * c + i, c + 3, i);
      applyStimulus(0, 0);
    end
    repeat (N + 4) applyStimulus(0, 0);

    // Pointer moves to 3, then requesters 0 and 2 compete
    setOp(2, 7, 7, 7);
    applyStimulus(0, 0);
    for (int c = 0; c < 3; c++) begin
      if (!pend[0]) setOp(0, 30 + c, 2, 1);
      if (!pend[2]) setOp(2, 40 + c, 3, 2);
      applyStimulus(0, 0);
    end
    repeat (5) applyStimulus(0, 0);
    for (int i = 0; i < N; i++) pend[i] = 1'b0;

    // Largest operands; the pointer ends at 1
    setOp(0, 255, 255, 255);
    repeat (5) applyStimulus(0, 0);

    // Stall while two ops are in flight
    setOp(1, 9, 11, 13);
    setOp(2, 100, 200, 50);
    repeat (2) applyStimulus(0, 0);
    repeat (4) applyStimulus(0, 1);
    repeat (5) applyStimulus(0, 0);

    // Reset with three ops in flight, then requester 3 alone
    setOp(0, 1, 2, 3);
    setOp(1, 4, 5, 6);
    setOp(2, 7, 8, 9);
    repeat (3) applyStimulus(0, 0);
    applyStimulus(1, 0);
    setOp(3, 50, 60, 70);
    repeat (6) applyStimulus(0, 0);

    // Random traffic with occasional stalls and resets
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0)
          setOp(i, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
      end
      applyStimulus($urandom_range(0, 49) == 0, $urandom_range(0, 5) == 0);
    end

    // Drain outstanding requests and results
    for (int k = 0; k < 60; k++) begin
      if (sb.size() == 0 && !pend[0] && !pend[1] && !pend[2] && !pend[3]) break;
      applyStimulus(0, 0);
    end
    done = 1'b1;
    for (int k = 0; k < 4 && !reported; k++) applyStimulus(0, 0);
    if (!reported) begin
      bad++;
      total++;
      $display("[TB] FAIL final_report actual=0 required=1");
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mac_share_arbiter.md
Name: mac_share_arbiter

Overview:
- Shares one pipelined 8x8 multiply-add unit (RES = A*B + C) among N_REQ requesters, using round-robin arbitration.
- Each requester presents its operands with REQ held high.
- The arbiter grants at most one requester per cycle and captures that requester's operands into a 2-stage input register pipeline.
- The arithmetic is computed from the last stage, and the result returns with the requester's ID.
- Sits between multiple filter/accumulate clients and the single shared multiplier resource.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of requester ID; must equal clog2(N_REQ).
- DW, 8, operand width of A, B and C.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RST  input  1  synchronous, active-high reset.
- REQ  input  N_REQ  per-requester request; held high until granted.
- A_IN  input  N_REQ*DW  packed A operands; requester i occupies bits [i*DW +: DW].
- B_IN  input  N_REQ*DW  packed B operands, same packing.
- C_IN  input  N_REQ*DW  packed C addends, same packing.
- STALL  input  1  freezes the arbiter and the pipeline while high.
- GNT  output  N_REQ  one-hot grant, combinational from REQ/STALL/pointer; accept occurs at the edge where GNT[i]=1.
- RES_VALID  output  1  registered; RES/RES_ID valid this cycle.
- RES  output  2*DW  registered A*B + C.
- RES_ID  output  ID_W  index of the requester that produced RES.
- BUSY  output  1  high while any pipeline stage holds a valid op.

Behaviour:
- Reset (RST=1 at an edge):
  - Priority pointer = 0.
  - All stage valids = 0, RES_VALID = 0, RES = 0, RES_ID = 0.
  - GNT forced to 0 while RST=1.
  - In-flight ops are discarded; no RES_VALID is produced for them.
- Arbitration:
  - Search REQ starting at the pointer index and moving upward with wrap-around. The first set bit wins.
  - GNT = 0 when STALL=1 or REQ=0.
  - On an accept by requester k, the pointer becomes (k+1) mod N_REQ.
  - With no accept, the pointer holds.
- Pipeline, per stage {valid, A, B, C, ID}:
  - S1 loads the granted requester's operands.
  - S2 loads from S1.
  - The output register loads A2*B2 + C2, zero-extended to 2*DW, then added. No overflow: max 255*255+255 = 65280.
  - Latency: an accept at edge t gives RES_VALID=1 in the cycle after edge t+2, i.e. 3 cycles after GNT.
  - Throughput: 1 op per cycle.
- RES_VALID is a single-cycle pulse per op. RES and RES_ID hold their last value when RES_VALID=0.
- STALL=1:
  - No grant.
  - S1, S2, the output register and the pointer all hold.
  - RES_VALID is held at its current value; a held result is not re-counted by the consumer while STALL=1.
  - After STALL deasserts, the pipeline resumes with no loss and no duplication.
- Simultaneous events:
  - A REQ change in the same cycle as a grant is irrelevant; only the sampled edge matters.
  - A granted requester may deassert REQ or present new operands on the next cycle.
  - A requester that keeps REQ=1 continuously is re-granted only after all other active requesters have been served once.
- BUSY = S1.valid | S2.valid | RES_VALID.
- Bubble slots (no grant) propagate as valid=0. Operand registers need not be cleared for a bubble.

Test Plan:
- Single op: after reset, REQ=0001, A=12, B=10, C=5 → GNT=0001 in cycle 0; RES_VALID=1, RES=125, RES_ID=0 three cycles later; BUSY high for cycles 1..3.
- Round-robin fairness: REQ=1111 held for 8 cycles with distinct operands → grant order 0,1,2,3,0,1,2,3; results emerge in the same order, one per cycle, with matching RES_ID.
- Pointer wrap and skip: pointer at 3, REQ=0101 → grant 0, then grant 2, then grant 0.
- Max arithmetic: A=255, B=255, C=255 → RES=65280 (0xFF00).
- STALL mid-flight: issue ops to requesters 1 and 2 back to back, then STALL=1 for 4 cycles once both are in S1/S2 → GNT=0, outputs frozen; after release each result appears exactly once, ids 1 then 2.
- Reset mid-operation: 3 ops in flight, RST=1 for one cycle → RES_VALID=0, BUSY=0, no stale results afterwards; next REQ=1000 is granted to requester 3 after the pointer resets to 0.
